// File: rtl/cfi_log_arbiter.sv
// CFI log arbiter: compacts relevant per-port commit records into a circular FIFO
// and serialises them to the CFI checker. Define CFI_LOG_DROP_EN to drop on overflow.
package cfi_log_pkg;
   localparam int unsigned VLEN = 32;

   typedef struct packed {
      logic branch;
      logic jump;
      logic call;
      logic ret;
   } cfi_flags_t;

   typedef struct packed {
      cfi_flags_t      flags;
      logic [VLEN-1:0] addr_pc;
      logic [VLEN-1:0] addr_next;
      logic [VLEN-1:0] addr_target;
   } cfi_log_t;
endpackage

module cfi_log_arbiter
   import cfi_log_pkg::*;
#(
   parameter int unsigned NrPorts = 2,
   parameter int unsigned Depth   = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic [NrPorts-1:0]           valid_i,
   input  cfi_log_t [NrPorts-1:0]       log_i,
   output logic [NrPorts-1:0]           ready_o,
   output logic                         out_valid_o,
   output cfi_log_t                     out_log_o,
   input  logic                         out_ready_i,
   output logic [$clog2(Depth+1)-1:0]   count_o,
   output logic [31:0]                  drop_cnt_o
);

   localparam int unsigned CW = $clog2(Depth + 1);
   localparam int unsigned PW = $clog2(Depth);

   cfi_log_t           mem_q [Depth];
   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]      free;
   logic [NrPorts-1:0] relevant;
   logic [NrPorts-1:0] store;
   logic [PW-1:0]      waddr [NrPorts];
   logic [CW-1:0]      n_push;
   logic               pop;
`ifdef CFI_LOG_DROP_EN
   logic [CW-1:0]      n_rel;
`else
   logic               accept;

   assign accept = (free >= CW'(NrPorts));
`endif

   assign free        = CW'(Depth) - count_q;
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o & out_ready_i;
   assign out_log_o   = out_valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o     = count_q;

   // Relevant records are packed into consecutive slots in port order; n_push
   // doubles as the running write offset for the next stored record.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      relevant = '0;
      store    = '0;
      n_push   = '0;
`ifdef CFI_LOG_DROP_EN
      n_rel    = '0;
`endif
      for (int p = 0; p < NrPorts; p++) begin
         waddr[p]    = wr_ptr_q + n_push[PW-1:0];
         relevant[p] = valid_i[p] & (|log_i[p].flags);
`ifdef CFI_LOG_DROP_EN
         store[p]    = relevant[p] & (n_push < free);
         if (relevant[p]) n_rel = n_rel + CW'(1);
`else
         store[p]    = relevant[p] & accept;
`endif
         if (store[p]) n_push = n_push + CW'(1);
      end
   end

   always_comb begin
      count_d  = count_q + n_push - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
   end

   // NOTE: the storage array has no reset; occupancy and pointers alone define which entries are live.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NrPorts; p++) begin
         if (store[p]) mem_q[waddr[p]] <= log_i[p];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else if (flush_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

`ifdef CFI_LOG_DROP_EN
   logic [31:0] drop_q;
   logic [CW-1:0] n_drop;
   logic [32:0] drop_sum;

   assign n_drop   = n_rel - n_push;
   assign drop_sum = {1'b0, drop_q} + 33'(n_drop);

   // Drop count survives flush; only reset clears it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_q <= '0;
      end else if (!flush_i) begin
         drop_q <= drop_sum[32] ? '1 : drop_sum[31:0];
      end
   end

   assign drop_cnt_o = drop_q;
   assign ready_o    = '1;
`else
   assign drop_cnt_o = '0;
   assign ready_o    = {NrPorts{accept}};
`endif

endmodule

// File: tb/tb_cfi_log_arbiter.sv
// Directed bench for cfi_log_arbiter with an in-order scoreboard on the output stream.
module tb_cfi_log_arbiter;
   import cfi_log_pkg::*;

   localparam int NrPorts = 2;
   localparam int Depth   = 8;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            flush_i;
   logic [1:0]      valid_i;
   cfi_log_t [1:0]  log_i;
   logic [1:0]      ready_o;
   logic            out_valid_o;
   cfi_log_t        out_log_o;
   logic            out_ready_i;
   logic [3:0]      count_o;
   logic [31:0]     drop_cnt_o;

   cfi_log_t        sb [$];
   int              n_assert = 0;
   int              n_fail   = 0;
   logic [31:0]     exp_drop = '0;
   int              i_pair;
   int              budget;

   always #5 clk = ~clk;

   cfi_log_arbiter #(.NrPorts(NrPorts), .Depth(Depth)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .log_i       (log_i),
      .ready_o     (ready_o),
      .out_valid_o (out_valid_o),
      .out_log_o   (out_log_o),
      .out_ready_i (out_ready_i),
      .count_o     (count_o),
      .drop_cnt_o  (drop_cnt_o)
   );

   function automatic cfi_log_t mk(input logic [3:0] fl, input logic [31:0] pc);
      cfi_log_t r;
      r.flags       = cfi_flags_t'(fl);
      r.addr_pc     = pc;
      r.addr_next   = pc + 32'd4;
      r.addr_target = pc ^ 32'h0000_8000;
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [1:0] v, input cfi_log_t l0, input cfi_log_t l1, input bit rec);
      valid_i  = v;
      log_i[0] = l0;
      log_i[1] = l1;
      if (rec) begin
         if (v[0] && (|l0.flags)) sb.push_back(l0);
         if (v[1] && (|l1.flags)) sb.push_back(l1);
      end
   endtask

   task automatic drain();
      int n = 0;
      valid_i     = '0;
      out_ready_i = 1'b1;
      while (sb.size() != 0 && n < 64) begin
         tick();
         n++;
      end
      check("drain_sb_empty", sb.size(), 0);
      check("drain_count", count_o, 0);
      out_ready_i = 1'b0;
   endtask

   // Every handshake retires the oldest expected record.
   always @(negedge clk) begin
      if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
         if (sb.size() == 0) check("sb_underflow", out_valid_o, 1'b0);
         else                check("out_log", out_log_o, sb.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; valid_i = '0; out_ready_i = 1'b0; log_i = '0;
      tick();
      tick();
      rst_i = 1'b0;
      check("rst_count", count_o, 0);
      check("rst_valid", out_valid_o, 0);
      check("rst_ready", ready_o, 2'b11);
      check("rst_drop", drop_cnt_o, 0);
      check("rst_log", out_log_o, 0);
      tick();
      check("idle_count", count_o, 0);

      // Compaction: irrelevant port 0 is skipped, port 1 call lands in the first slot.
      set_in(2'b11, mk(4'b0000, 32'h50), mk(4'b0010, 32'h100), 1'b1);
      check("no_bypass_valid", out_valid_o, 0);
      tick();
      valid_i = '0;
      check("compact_count", count_o, 1);
      check("compact_valid", out_valid_o, 1);
      check("compact_pc", out_log_o.addr_pc, 32'h100);
      check("compact_call", out_log_o.flags.call, 1);
      tick();
      check("hold_pc", out_log_o.addr_pc, 32'h100);
      drain();

      // Ordering and wrap: 10 pairs with ascending pcs, consumer always ready.
      out_ready_i = 1'b1;
      i_pair = 0;
      budget = 0;
      while (i_pair < 10 && budget < 100) begin
         if (Depth - int'(count_o) >= 2) begin
            set_in(2'b11, mk(4'b1000, 32'(8 * i_pair)), mk(4'b0100, 32'(8 * i_pair + 4)), 1'b1);
            i_pair++;
         end else begin
            valid_i = '0;
         end
         tick();
         budget++;
      end
      check("wrap_pairs", i_pair, 10);
      drain();

`ifndef CFI_LOG_DROP_EN
      // Backpressure: fill to full, hold a pending pair, then release.
      for (int k = 0; k < 4; k++) begin
         check("bp_ready_open", ready_o, 2'b11);
         set_in(2'b11, mk(4'b1000, 32'(32'h300 + 8 * k)), mk(4'b0001, 32'(32'h304 + 8 * k)), 1'b1);
         tick();
      end
      set_in(2'b11, mk(4'b0100, 32'h340), mk(4'b0010, 32'h344), 1'b0);
      check("bp_full_count", count_o, 8);
      check("bp_full_ready", ready_o, 2'b00);
      tick();
      check("bp_hold_count", count_o, 8);
      out_ready_i = 1'b1;
      #1;
      check("bp_no_comb_path", ready_o, 2'b00);
      tick();
      check("bp_cnt7", count_o, 7);
      check("bp_ready7", ready_o, 2'b00);
      tick();
      check("bp_cnt6", count_o, 6);
      check("bp_ready6", ready_o, 2'b11);
      sb.push_back(log_i[0]);
      sb.push_back(log_i[1]);
      tick();
      check("bp_after_release", count_o, 7);
      check("bp_drop_zero", drop_cnt_o, 0);
      drain();
`else
      // Overflow: one free slot, two relevant records; port 1 is dropped.
      for (int k = 0; k < 3; k++) begin
         set_in(2'b11, mk(4'b1000, 32'(32'h380 + 8 * k)), mk(4'b0001, 32'(32'h384 + 8 * k)), 1'b1);
         tick();
      end
      set_in(2'b01, mk(4'b1000, 32'h3c0), mk(4'b0000, 32'h0), 1'b1);
      tick();
      check("drop_cnt7", count_o, 7);
      check("drop_ready", ready_o, 2'b11);
      set_in(2'b11, mk(4'b1000, 32'h400), mk(4'b0001, 32'h404), 1'b0);
      sb.push_back(log_i[0]);
      tick();
      valid_i = '0;
      exp_drop = 32'd1;
      check("drop_count_full", count_o, 8);
      check("drop_cnt", drop_cnt_o, exp_drop);
      drain();
`endif

      // Flush at occupancy 5 with a simultaneous push and pop.
      out_ready_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         set_in(2'b11, mk(4'b0010, 32'(32'h600 + 8 * k)), mk(4'b0001, 32'(32'h604 + 8 * k)), 1'b1);
         tick();
      end
      set_in(2'b01, mk(4'b0100, 32'h610), mk(4'b0000, 32'h0), 1'b1);
      tick();
      check("pre_flush_count", count_o, 5);
      sb.delete();
      flush_i = 1'b1;
      out_ready_i = 1'b1;
      set_in(2'b11, mk(4'b1000, 32'h700), mk(4'b1000, 32'h704), 1'b0);
      tick();
      flush_i = 1'b0;
      out_ready_i = 1'b0;
      valid_i = '0;
      check("flush_count", count_o, 0);
      check("flush_valid", out_valid_o, 0);
      check("flush_keeps_drop", drop_cnt_o, exp_drop);
      set_in(2'b01, mk(4'b0100, 32'h200), mk(4'b0000, 32'h0), 1'b1);
      tick();
      valid_i = '0;
      check("post_flush_pc", out_log_o.addr_pc, 32'h200);
      drain();

      // Reset mid-stream discards buffered data and clears the drop counter.
      set_in(2'b01, mk(4'b0001, 32'h500), mk(4'b0000, 32'h0), 1'b0);
      tick();
      valid_i = '0;
      check("pre_rst_count", count_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("mid_rst_count", count_o, 0);
      check("mid_rst_valid", out_valid_o, 0);
      check("mid_rst_drop", drop_cnt_o, 0);
      check("mid_rst_log", out_log_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cfi_log_arbiter.md
# cfi_log_arbiter

Collects CFI log records (flags, PC, next PC, target) from the commit ports in program order and serialises them into a single valid/ready stream toward the CFI checker. Sits between commit and the CFI stage; port 0 is always the oldest instruction in a cycle. Records with no CFI flag set are discarded at the input. A circular FIFO decouples commit bursts from checker throughput.

## Interface
- NrPorts, 2: number of commit ports (1..4).
- Depth, 8: FIFO entries (power of two, >= NrPorts).
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all buffered records.
- valid_i  in  NrPorts  per-port record valid.
- log_i  in  NrPorts x cfi_log_t  per-port record: 4 flag bits + 3*VLEN address bits.
- ready_o  out  NrPorts  per-port accept; all bits always equal.
- out_valid_o  out  1  head record valid.
- out_log_o  out  cfi_log_t  head record.
- out_ready_i  in  1  checker consumes head.
- count_o  out  $clog2(Depth+1)  current occupancy.
- drop_cnt_o  out  32  records dropped on overflow (tied 0 without macro).

## Operation
- Relevant record: valid_i[p] and at least one of branch/jump/call/ret set. Non-relevant valid records are accepted and discarded; they never occupy an entry.
- Accept rule: ready_o = all ones iff (Depth - count) >= NrPorts, computed from registered count only. No path from out_ready_i to ready_o.
- Push: on accept, relevant records are written to consecutive entries in ascending port order, compacting gaps (valid-but-irrelevant or invalid ports). k relevant records advance the write pointer by k.
- Pop: out_valid_o and out_ready_i both high -> head retires, read pointer +1.
- Simultaneous push/pop: count_next = count + k - pop; permitted at any occupancy including full.
- Pointers: log2(Depth) bits, wrap modulo Depth; full/empty derived from count, not pointer equality.
- flush_i: next cycle count=0, pointers=0, out_valid_o=0; pushes and pops in the flush cycle are discarded. flush_i has priority over push/pop; rst_i has priority over flush_i.
- out_log_o is the head entry, stable while out_valid_o high and out_ready_i low.
- Reset: count_o=0, out_valid_o=0, out_log_o=0, drop_cnt_o=0, ready_o=all ones (Depth >= NrPorts), pointers=0. Reset mid-stream drops all buffered records.

## Timing
- Record accepted in cycle N appears at out_valid_o in cycle N+1 at earliest (registered storage, no bypass).
- Throughput: up to NrPorts records in per cycle, 1 out per cycle.
- ready_o reflects state at start of cycle; if low, commit must hold valid_i/log_i unchanged until ready_o returns.
- count_o updates one cycle after the push/pop/flush that changed it.

## Configuration
- CFI_LOG_DROP_EN defined: ready_o is constantly all ones; when a cycle's relevant records exceed free space, the records that fit are stored in port order, the rest discarded; drop_cnt_o increments by the number discarded, saturating at 0xFFFFFFFF; cleared only by rst_i (not flush_i).
- Not defined: backpressure per Accept rule; drop_cnt_o tied to 0; no records ever lost except by flush_i/rst_i.

## Test plan
- Reset then idle: after rst_i high 1 cycle -> count_o=0, out_valid_o=0, ready_o=2'b11, drop_cnt_o=0.
- Compaction: port0 valid flags=0, port1 valid call pc=0x100 -> count_o=1 next cycle, out_log_o.addr_pc=0x100, flags.call=1.
- Ordering/wrap: Depth=8, out_ready_i=1, push 2 relevant records/cycle for 10 cycles (pc 0x0,0x4,...) -> output pcs strictly ascending by 4, no gaps, pointers wrap twice.
- Backpressure (no macro): out_ready_i=0, push 2/cycle -> after 4 cycles count_o=8, ready_o=0; with count_o=7 ready_o=0; raise out_ready_i -> ready_o returns 1 when count_o<=6.
- Drop (macro): count=7, out_ready_i=0, 2 relevant records -> port0 stored, count_o=8, drop_cnt_o=1; port1 record never appears at output.
- Flush: count=5, flush_i with simultaneous push and pop -> next cycle count_o=0, out_valid_o=0; next pushed record pc=0x200 is first output.
